// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder backed by a 64-bit word array.
// Optional macro DMEM_MISALIGN_CHECK_EN faults misaligned accesses instead of aligning them down.
module dmem_responder #(
    parameter int DEPTH_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic        accept_s;
    logic        req_ready_r;
    logic        resp_valid_r, resp_err_r;
    logic [63:0] resp_rdata_r;
    logic        we_r, signed_r;
    logic [63:0] addr_r, wdata_r;
    logic [1:0]  size_r;

    logic [63:0] mem_r [DEPTH_WORDS];

    logic [AW-1:0] idx_s;
    logic [2:0]    off_s;
    logic          range_err_s, align_err_s, err_s, commit_s;
    logic [7:0]    wmask_s;
    logic [63:0]   wdata_sh_s, rword_sh_s, rdata_s;

    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] low_bits(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            2'd0:    return sgn ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
            2'd1:    return sgn ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
            2'd2:    return sgn ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    // Access decode from the captured request: word index, lane offset, fault.
    always_comb begin
        idx_s       = addr_r[3 +: AW];
        range_err_s = (addr_r >> (AW + 3)) != 64'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
        off_s       = addr_r[2:0];
        align_err_s = (addr_r[2:0] & low_bits(size_r)) != 3'd0;
`else
        off_s       = addr_r[2:0] & ~low_bits(size_r);
        align_err_s = 1'b0;
`endif
        err_s       = range_err_s | align_err_s;
        wmask_s     = lane_mask(size_r) << off_s;
        wdata_sh_s  = wdata_r << {off_s, 3'b000};
        rword_sh_s  = mem_r[idx_s] >> {off_s, 3'b000};
        rdata_s     = (err_s || we_r) ? 64'd0 : extend(rword_sh_s, size_r, signed_r);
        commit_s    = (state_r == ACCESS) && we_r && !err_s;
    end

    // Next-state logic for the IDLE/ACCESS/RESP handshake sequence.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    state_s  = ACCESS;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACCESS: state_s = RESP;
            RESP: begin
                if (resp_valid_r && resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, request capture and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 64'd0;
            resp_err_r   <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 64'd0;
            size_r       <= 2'd0;
            signed_r     <= 1'b0;
            wdata_r      <= 64'd0;
        end else begin
            state_r     <= state_s;
            // Ready only follows a full return to IDLE, so a handshake cycle never accepts.
            req_ready_r <= (state_s == IDLE);
            if (accept_s) begin
                we_r     <= req_we;
                addr_r   <= req_addr;
                size_r   <= req_size;
                signed_r <= req_signed;
                wdata_r  <= req_wdata;
            end
            if (state_r == ACCESS) begin
                resp_valid_r <= 1'b1;
                resp_rdata_r <= rdata_s;
                resp_err_r   <= err_s;
            end else if (state_r == RESP && resp_ready) begin
                resp_valid_r <= 1'b0;
                resp_rdata_r <= 64'd0;
                resp_err_r   <= 1'b0;
            end
        end
    end

    // Byte-masked store commit on the edge leaving ACCESS; storage has no reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (default DEPTH_WORDS=512).
module tb_dmem_responder;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
    logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
    logic [1:0]  req_size = 2'd0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [63:0] resp_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.sgn = sgn; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // One full request/response; inputs are scrambled after acceptance, response stalled 'hold' cycles.
    task automatic xact(input logic we, input logic [63:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [63:0] wdata, input int hold,
                        output logic [63:0] rdata, output logic err, output int cyc);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wdata; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("req_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_size = ~size;
        req_signed = ~sgn; req_wdata = ~wdata;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("stall_valid", {63'd0, resp_valid}, 64'd1);
            chk("stall_rdata", resp_rdata, rdata);
            chk("stall_err", {63'd0, resp_err}, {63'd0, err});
            chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_hs_valid", {63'd0, resp_valid}, 64'd0);
        chk("post_hs_req_ready", {63'd0, req_ready}, 64'd1);
    endtask

    logic [63:0] rd;
    logic        er;
    int          cyc;

    initial begin
        add(1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, 64'd0, 1'b0);
        add(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 64'h1122334455667788, 1'b0);
        add(1'b1, 64'h13, 2'd0, 1'b0, 64'hDEADBEEFCAFEBA80, 64'd0, 1'b0);
        add(1'b0, 64'h13, 2'd0, 1'b1, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0);
        add(1'b0, 64'h13, 2'd0, 1'b0, 64'd0, 64'h80, 1'b0);
        add(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 64'h1122334480667788, 1'b0);
        add(1'b0, 64'h16, 2'd1, 1'b1, 64'd0, 64'h1122, 1'b0);
        add(1'b0, 64'h14, 2'd2, 1'b1, 64'd0, 64'h11223344, 1'b0);
        add(1'b1, 64'h18, 2'd3, 1'b0, 64'hFEDCBA9876543210, 64'd0, 1'b0);
        add(1'b1, 64'h1A, 2'd1, 1'b0, 64'h000000000000ABCD, 64'd0, 1'b0);
        add(1'b0, 64'h18, 2'd3, 1'b0, 64'd0, 64'hFEDCBA98ABCD3210, 1'b0);
        add(1'b0, 64'h1C, 2'd2, 1'b1, 64'd0, 64'hFFFFFFFFFEDCBA98, 1'b0);
        add(1'b0, 64'h1A, 2'd1, 1'b0, 64'd0, 64'h000000000000ABCD, 1'b0);
        add(1'b0, 64'h1A, 2'd1, 1'b1, 64'd0, 64'hFFFFFFFFFFFFABCD, 1'b0);
        add(1'b1, 64'h0, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'd0, 1'b0);
        add(1'b0, DEPTH * 8, 2'd1, 1'b0, 64'd0, 64'd0, 1'b1);
        add(1'b1, DEPTH * 8, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        add(1'b0, 64'h0, 2'd3, 1'b0, 64'd0, 64'h0123456789ABCDEF, 1'b0);
        add(1'b1, 64'h8000000000000000, 2'd3, 1'b0, 64'h5A5A5A5A5A5A5A5A, 64'd0, 1'b1);
        add(1'b0, 64'h0, 2'd3, 1'b0, 64'd0, 64'h0123456789ABCDEF, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
        add(1'b0, 64'h12, 2'd2, 1'b0, 64'd0, 64'd0, 1'b1);
        add(1'b1, 64'h19, 2'd1, 1'b0, 64'h7777, 64'd0, 1'b1);
        add(1'b0, 64'h18, 2'd3, 1'b0, 64'd0, 64'hFEDCBA98ABCD3210, 1'b0);
`else
        add(1'b0, 64'h12, 2'd2, 1'b0, 64'd0, 64'h0000000080667788, 1'b0);
        add(1'b1, 64'h19, 2'd1, 1'b0, 64'h7777, 64'd0, 1'b0);
        add(1'b0, 64'h18, 2'd3, 1'b0, 64'd0, 64'hFEDCBA98ABCD7777, 1'b0);
`endif
        add(1'b1, 64'h20, 2'd3, 1'b0, 64'h5555555555555555, 64'd0, 1'b0);

        // Reset values while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready_before_edge", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("rel_req_ready_first_edge", {63'd0, req_ready}, 64'd1);

        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wdata, 0,
                 rd, er, cyc);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_latency", i), cyc, 64'd2);
        end

        // Back-pressure: response held for 5 cycles.
        xact(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 5, rd, er, cyc);
        chk("stall_load_rdata", rd, 64'h1122334480667788);
        chk("stall_load_latency", cyc, 64'd2);

        // Reset during ACCESS of a byte store: no commit, response dropped.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20; req_size = 2'd0;
        req_signed = 1'b0; req_wdata = 64'hAA;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstacc_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rstacc_req_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("rstacc_resp_valid_held", {63'd0, resp_valid}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rstacc_req_ready_released", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("rstacc_req_ready_edge", {63'd0, req_ready}, 64'd1);
        xact(1'b0, 64'h20, 2'd0, 1'b0, 64'd0, 0, rd, er, cyc);
        chk("rstacc_byte_unchanged", rd, 64'h55);
        chk("rstacc_err", {63'd0, er}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
